// File: rtl/apb_slave_regfile.sv
// APB completer holding a DEPTH x DATA_W register file with programmable
// access-phase wait states and pslverr for out-of-range addresses.
module apb_slave_regfile #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] a_addr;
    logic              a_wr;
    logic [DATA_W-1:0] a_data;
    logic [3:0]        wcnt;

    logic              setup;
    logic              setup_err;
    logic              acc_err;
    logic [DATA_W-1:0] setup_rd;
    logic [DATA_W-1:0] acc_rd;

    // Unsigned compare on the full address, one extra bit so DEPTH == 2**ADDR_W fits.
    assign setup     = psel && !penable;
    assign setup_err = {1'b0, paddr} >= DEPTH_X;
    assign acc_err   = {1'b0, a_addr} >= DEPTH_X;
    assign setup_rd  = setup_err ? '0 : regs[paddr[IDX_W-1:0]];
    assign acc_rd    = acc_err ? '0 : regs[a_addr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (prst) begin
            state   <= IDLE;
            wcnt    <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            a_addr  <= '0;
            a_wr    <= 1'b0;
            a_data  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (setup) begin
                        a_addr <= paddr;
                        a_wr   <= pwrite;
                        a_data <= pwdata;
                        wcnt   <= WS;
                        state  <= ACCESS;
                        // Zero wait states: the response is ready on the first access cycle.
                        if (WS == 4'd0) begin
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            if (!pwrite) prdata <= setup_rd;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        wcnt    <= '0;
                        state   <= IDLE;
                    end else if (penable) begin
                        if (pready) begin
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            state   <= DONE;
                            if (a_wr && !acc_err) regs[a_addr[IDX_W-1:0]] <= a_data;
                        end else if (wcnt > 4'd1) begin
                            wcnt <= wcnt - 4'd1;
                        end else begin
                            wcnt    <= '0;
                            pready  <= 1'b1;
                            pslverr <= acc_err;
                            if (!a_wr) prdata <= acc_rd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
